run_step_ctrl: RTL

- Front-end run controller that sits directly upstream of single_cycle.
- Turns the raw run push-button into debounced, edge-detected CPU clock-enable pulses.
- Supports single-step and free-run modes, stops on a CPU halt indication, and counts issued steps for the register-inspection bench and display logic.
- Drives the enable that single_cycle consumes in place of a direct switch_run level.

---
 rtl/single_cycle_pkg.sv | 17 +
 rtl/debounce_sync.sv | 50 +++++
 rtl/run_step_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/single_cycle_pkg.sv
// Shared types and defaults for the single_cycle run/step front end.
// Holds the run controller state encoding and default timing constants.
package single_cycle_pkg;

    localparam int STATE_W          = 3;
    localparam int DEBOUNCE_DEFAULT = 8;
    localparam int RUN_DIV_DEFAULT  = 1;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 3'd0,
        STEP     = 3'd1,
        WAIT_REL = 3'd2,
        RUN      = 3'd3,
        HALTED   = 3'd4
    } state_e;

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchronizer plus debouncer for a bouncy push-button.
// Ports: fastclk, reset (async, active low), din (raw button),
//        stable (debounced level), press / release_pulse (1-cycle edges).
module debounce_sync
    import single_cycle_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic fastclk,
    input  logic reset,
    input  logic din,
    output logic stable,
    output logic press,
    output logic release_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    logic             stable_q;

    // The counter flips stable on the cycle it would reach
    // DEBOUNCE_CYCLES, so stable changes after exactly that many
    // consecutive disagreeing samples.
    always_ff @(posedge fastclk or negedge reset) begin
        if (!reset) begin
            sync     <= '0;
            cnt      <= '0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            sync     <= {sync[0], din};
            stable_q <= stable;
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign press         = stable & ~stable_q;
    assign release_pulse = ~stable & stable_q;

endmodule

// File: rtl/run_step_ctrl.sv
// Run/step controller producing CPU clock-enable pulses from a button.
// Ports: fastclk, reset (async, active low), switch_run, switch_cont,
//        cpu_halt in; cpu_en, step_count, state_out, run_active out.
module run_step_ctrl
    import single_cycle_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int RUN_DIV         = RUN_DIV_DEFAULT,
    parameter int COUNT_W         = 32
) (
    input  logic               fastclk,
    input  logic               reset,
    input  logic               switch_run,
    input  logic               switch_cont,
    input  logic               cpu_halt,
    output logic               cpu_en,
    output logic [COUNT_W-1:0] step_count,
    output logic [STATE_W-1:0] state_out,
    output logic               run_active
);

    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    state_e           state;
    state_e           state_nx;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nx;
    logic [1:0]       cont_sync;
    logic             sync_cont;
    logic             stable;
    logic             press;
    logic             rel;
    logic             unused_rel;

    debounce_sync #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_run_db (
        .fastclk      (fastclk),
        .reset        (reset),
        .din          (switch_run),
        .stable       (stable),
        .press        (press),
        .release_pulse(rel)
    );

    // WAIT_REL leaves on the stable level, so the edge pulse is spare.
    assign unused_rel = rel;
    assign sync_cont  = cont_sync[1];

    always_ff @(posedge fastclk or negedge reset) begin
        if (!reset) begin
            cont_sync  <= '0;
            state      <= IDLE;
            div_cnt    <= '0;
            step_count <= '0;
        end else begin
            cont_sync <= {cont_sync[0], switch_cont};
            state     <= state_nx;
            div_cnt   <= div_nx;
            if (cpu_en) begin
                step_count <= step_count + COUNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nx = state;
        div_nx   = div_cnt;
        case (state)
            IDLE: begin
                if (cpu_halt) begin
                    state_nx = HALTED;
                end else if (press) begin
                    if (sync_cont) begin
                        state_nx = RUN;
                        div_nx   = '0;
                    end else begin
                        state_nx = STEP;
                    end
                end
            end
            STEP: begin
                state_nx = cpu_halt ? HALTED : WAIT_REL;
            end
            WAIT_REL: begin
                if (cpu_halt) begin
                    state_nx = HALTED;
                end else if (!stable) begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                if (cpu_halt) begin
                    state_nx = HALTED;
                end else if (press) begin
                    state_nx = WAIT_REL;
                end
                if (div_cnt == DIV_LAST) begin
                    div_nx = '0;
                end else begin
                    div_nx = div_cnt + DIV_W'(1);
                end
            end
            HALTED: begin
                state_nx = HALTED;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Decoded purely from registers so the enable cannot glitch.
    assign cpu_en     = (state == STEP) |
                        ((state == RUN) & (div_cnt == '0));
    assign state_out  = state;
    assign run_active = (state == RUN);

endmodule
